writeback_queue: RTL

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/writeback_queue.sv
// ---------------------------------------------------------------------------
// writeback_queue
//
// Small in-order queue of deferred register-file writes.
//
// A producer (e.g. a long-latency unit) hands over {rd, data} pairs.
// The queue commits them to the register unit whenever the main pipeline
// leaves the write port free. Writes drain strictly in acceptance order.
// A lookup port reports whether a source register still has a queued write,
// and forwards the value of the youngest such write.
//
// Parameters
//   DEPTH     number of queued write requests (power of two, >= 2)
//
// Ports
//   Clk       clock, rising edge
//   Rst       synchronous active-high reset
//   InValid   producer offers {InRd, InData} this cycle
//   InRd      destination register of the offered request
//   InData    value to write
//   InReady   queue can accept a request this cycle (count < DEPTH)
//   WbStall   register-file write port is busy this cycle
//   RuWr      write enable to the register unit
//   Rd        register being written (head entry, 0 when empty)
//   RuDataWr  value being written (head entry, 0 when empty)
//   Rs1, Rs2  source registers to look up
//   Pend1/2   a queued write targets Rs1/Rs2
//   Fwd1/2    data of the youngest queued write to Rs1/Rs2 (0 if none)
// ---------------------------------------------------------------------------
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        InValid,
    input  logic [4:0]  InRd,
    input  logic [31:0] InData,
    output logic        InReady,
    input  logic        WbStall,
    output logic        RuWr,
    output logic [4:0]  Rd,
    output logic [31:0] RuDataWr,
    input  logic [4:0]  Rs1,
    input  logic [4:0]  Rs2,
    output logic        Pend1,
    output logic        Pend2,
    output logic [31:0] Fwd1,
    output logic [31:0] Fwd2
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry storage
    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];

    // Queue bookkeeping
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             not_empty;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] lkp_idx;

    // -----------------------------------------------------------------------
    // Handshake and drain control
    // -----------------------------------------------------------------------
    assign not_empty = (count_q != '0);

    // Ready looks only at the current fill level, never at a same-cycle
    // drain, so it cannot form a combinational path from WbStall.
    assign InReady   = (count_q < CNT_W'(DEPTH));

    // Writes to x0 are accepted (handshake completes) but never stored.
    assign push      = InValid && InReady && (InRd != 5'd0);

    assign RuWr      = not_empty && !WbStall;
    assign pop       = RuWr;

    assign Rd        = not_empty ? rd_q[head_q]   : 5'd0;
    assign RuDataWr  = not_empty ? data_q[head_q] : 32'd0;

    // -----------------------------------------------------------------------
    // Next-state logic for pointers and count
    // -----------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (push) begin
            tail_d = tail_q + 1'b1;   // wraps DEPTH-1 -> 0 (power-of-two depth)
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end

        // Simultaneous push and pop leaves the count unchanged.
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the entry array is deliberately not reset; count_q == 0 marks
    // every slot invalid, and leaving data unreset keeps it a plain RAM.
    always_ff @(posedge Clk) begin
        if (push) begin
            rd_q[tail_q]   <= InRd;
            data_q[tail_q] <= InData;
        end
    end

    // -----------------------------------------------------------------------
    // Pending-write lookup
    //
    // Walk the occupied entries from oldest (head) to youngest; a later match
    // overrides an earlier one, so the forwarded value is the youngest write.
    // The head is included even when it is being drained this cycle, because
    // the register unit only holds the value after the edge. The request on
    // the input port is not yet queued and is not considered.
    // -----------------------------------------------------------------------
    always_comb begin
        Pend1   = 1'b0;
        Pend2   = 1'b0;
        Fwd1    = 32'd0;
        Fwd2    = 32'd0;
        lkp_idx = head_q;

        for (int i = 0; i < DEPTH; i++) begin
            lkp_idx = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if ((Rs1 != 5'd0) && (rd_q[lkp_idx] == Rs1)) begin
                    Pend1 = 1'b1;
                    Fwd1  = data_q[lkp_idx];
                end
                if ((Rs2 != 5'd0) && (rd_q[lkp_idx] == Rs2)) begin
                    Pend2 = 1'b1;
                    Fwd2  = data_q[lkp_idx];
                end
            end
        end
    end

endmodule
